// File: rtl/freq_divider_prog.sv
// Runtime-programmable clock-enable divider: 50 % square wave plus a
// one-cycle terminal-count strobe. New half-period values are held in a
// shadow register until a period boundary, so the output never glitches.
module freq_divider_prog #(
    parameter int unsigned WIDTH       = 26,
    parameter int unsigned DEFAULT_DIV = 62499999
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             sync,
    input  logic [WIDTH-1:0] div_val,
    input  logic             div_load,
    output logic             out,
    output logic             tick,
    output logic             pending,
    output logic [WIDTH-1:0] cur_div
);

    localparam logic [WIDTH-1:0] DIV_RST = WIDTH'(DEFAULT_DIV);

    logic [WIDTH-1:0] counter;
    logic [WIDTH-1:0] shadow;
    logic             terminal;

    // Terminal count: end of the current half-period while counting.
    always_comb begin
        terminal = en && (counter == cur_div);
    end

    // Counter, outputs and reload handling; priority is
    // reset > sync > load/apply > count.
    always_ff @(posedge clk) begin
        if (reset) begin
            counter <= '0;
            out     <= 1'b0;
            tick    <= 1'b0;
            pending <= 1'b0;
            cur_div <= DIV_RST;
            shadow  <= DIV_RST;
        end else if (sync) begin
            // Phase restart; a coincident load is still captured for later.
            counter <= '0;
            out     <= 1'b0;
            tick    <= 1'b0;
            if (div_load) begin
                shadow  <= div_val;
                pending <= 1'b1;
            end
        end else if (!en) begin
            // While frozen there is no period to protect, so a new value
            // takes effect at once and the counter restarts from zero; this
            // keeps counter <= cur_div at all times.
            tick <= 1'b0;
            if (div_load) begin
                cur_div <= div_val;
                shadow  <= div_val;
                counter <= '0;
                pending <= 1'b0;
            end else if (pending) begin
                cur_div <= shadow;
                counter <= '0;
                pending <= 1'b0;
            end
        end else if (terminal) begin
            counter <= '0;
            out     <= ~out;
            tick    <= 1'b1;
            if (div_load) begin
                cur_div <= div_val;
                shadow  <= div_val;
                pending <= 1'b0;
            end else if (pending) begin
                cur_div <= shadow;
                pending <= 1'b0;
            end
        end else begin
            counter <= counter + WIDTH'(1);
            tick    <= 1'b0;
            if (div_load) begin
                shadow  <= div_val;
                pending <= 1'b1;
            end
        end
    end

endmodule
